// File: rtl/pier_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pier_spi_pkg
// Purpose  : Shared constants for the Pier Solar EEPROM SPI master: register
//            addresses, CTRL/STATUS bit positions and the transfer state enum.
// Ports    : none (package)
// Config   : PIER_SPI_BITBANG_EN (used by the top, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package pier_spi_pkg;

    // Register addresses on bus_addr
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RAW    = 2'd3;

    // CTRL bit positions
    localparam int CTRL_CS_N   = 0;
    localparam int CTRL_HOLD_N = 1;
    localparam int CTRL_WP_N   = 2;

    // STATUS bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

    // RAW bit positions
    localparam int RAW_SCK = 0;
    localparam int RAW_SI  = 1;
    localparam int RAW_SO  = 2;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_LOW  = 2'd1,
        SPI_HIGH = 2'd2,
        SPI_DONE = 2'd3
    } spi_state_e;

endpackage : pier_spi_pkg
`default_nettype wire

// File: rtl/pier_spi_halfbit_timer.sv
`default_nettype none
// ============================================================================
// Module   : pier_spi_halfbit_timer
// Purpose  : Counts CLK_DIV clocks per SCK half-period and pulses tick on the
//            last clock of each half-period while run is high.
// Ports    : clk, reset_n (async, active-low), clear (sync), load (restart),
//            run (count enable), tick (one-clk pulse)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module pier_spi_halfbit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_count;

    assign tick = run && (r_count == c_LAST);

    // A tick wraps the count so consecutive half-periods need no reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 8'd0;
        end else if (clear || load || tick) begin
            r_count <= 8'd0;
        end else if (run) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule : pier_spi_halfbit_timer
`default_nettype wire

// File: rtl/pier_eeprom_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : pier_eeprom_spi_master
// Purpose  : Byte-wide mode-0 SPI master driving the M95320 EEPROM pins from
//            68k register accesses (DATA/CTRL/STATUS/RAW).
// Ports    : clk, reset_n, enable, bus_sel/bus_we/bus_addr/bus_di/bus_do,
//            busy, spi_si/spi_sck/spi_cs_n/spi_hold_n/spi_wp_n (out),
//            spi_so (in)
// Config   : PIER_SPI_BITBANG_EN - makes the RAW register live (bit-bang
//            sck/si in IDLE, read back sck/si/so). Undefined: RAW reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module pier_eeprom_spi_master
    import pier_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       bus_sel,
    input  logic       bus_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_di,
    output logic [7:0] bus_do,
    output logic       busy,
    output logic       spi_si,
    output logic       spi_sck,
    output logic       spi_cs_n,
    output logic       spi_hold_n,
    output logic       spi_wp_n,
    input  logic       spi_so
);

    spi_state_e r_state, w_state_next;

    logic [7:0] r_shift, r_rx, r_bus_do;
    logic [2:0] r_bit_idx;
    logic       r_rx_valid, r_overrun, r_cs_n, r_hold_n, r_wp_n;
    logic       w_tick, w_run, w_busy, w_sck, w_si;
    logic       w_raw_sck, w_raw_si;
    logic [7:0] w_raw_rd;

    // Bus decode
    logic w_wr, w_rd, w_data_wr, w_data_rd, w_ctrl_wr, w_stat_rd, w_start, w_abort;
    assign w_wr      = bus_sel & bus_we;
    assign w_rd      = bus_sel & ~bus_we;
    assign w_data_wr = w_wr & (bus_addr == REG_DATA);
    assign w_data_rd = w_rd & (bus_addr == REG_DATA);
    assign w_ctrl_wr = w_wr & (bus_addr == REG_CTRL);
    assign w_stat_rd = w_rd & (bus_addr == REG_STATUS);
    assign w_busy    = (r_state != SPI_IDLE);
    assign w_start   = w_data_wr & ~w_busy;
    // Deasserting chip select mid-byte abandons the transfer.
    assign w_abort   = w_ctrl_wr & w_busy & ~r_cs_n & bus_di[CTRL_CS_N];

    pier_spi_halfbit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~enable),
        .load    (w_start | w_abort),
        .run     (w_run),
        .tick    (w_tick)
    );

`ifdef PIER_SPI_BITBANG_EN
    logic r_raw_sck, r_raw_si;
    logic w_raw_wr;
    assign w_raw_wr = w_wr & (bus_addr == REG_RAW) & ~w_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_raw_sck <= 1'b0;
            r_raw_si  <= 1'b1;
        end else if (!enable) begin
            r_raw_sck <= 1'b0;
            r_raw_si  <= 1'b1;
        end else if (w_start) begin
            // sck must be low before the first LOW half-period
            r_raw_sck <= 1'b0;
        end else if (w_raw_wr) begin
            r_raw_sck <= bus_di[RAW_SCK];
            r_raw_si  <= bus_di[RAW_SI];
        end
    end

    assign w_raw_sck = r_raw_sck;
    assign w_raw_si  = r_raw_si;
    assign w_raw_rd  = {5'd0, spi_so, w_si, w_sck};
`else
    assign w_raw_sck = 1'b0;
    assign w_raw_si  = 1'b1;
    assign w_raw_rd  = 8'h00;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SPI_IDLE;
        end else if (!enable) begin
            r_state <= SPI_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SPI_IDLE: if (w_start) w_state_next = SPI_LOW;
            SPI_LOW:  if (w_tick)  w_state_next = SPI_HIGH;
            SPI_HIGH: if (w_tick)  w_state_next = (r_bit_idx == 3'd0) ? SPI_DONE : SPI_LOW;
            default:               w_state_next = SPI_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = SPI_IDLE;
        end
    end

    // Output logic
    always_comb begin
        w_sck = 1'b0;
        w_si  = 1'b1;
        w_run = 1'b0;
        case (r_state)
            SPI_IDLE: begin
                w_sck = w_raw_sck;
                w_si  = w_raw_si;
            end
            SPI_LOW: begin
                w_si  = r_shift[7];
                w_run = 1'b1;
            end
            SPI_HIGH: begin
                w_sck = 1'b1;
                w_si  = r_shift[7];
                w_run = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_rx       <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_cs_n     <= 1'b1;
            r_hold_n   <= 1'b1;
            r_wp_n     <= 1'b1;
            r_bus_do   <= 8'h00;
        end else if (!enable) begin
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_rx       <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_cs_n     <= 1'b1;
            r_hold_n   <= 1'b1;
            r_wp_n     <= 1'b1;
            r_bus_do   <= 8'h00;
        end else begin
            if (w_ctrl_wr) begin
                r_cs_n   <= bus_di[CTRL_CS_N];
                r_hold_n <= bus_di[CTRL_HOLD_N];
                r_wp_n   <= bus_di[CTRL_WP_N];
            end

            if (w_start) begin
                r_shift   <= bus_di;
                r_bit_idx <= 3'd7;
            end else if ((r_state == SPI_HIGH) && w_tick) begin
                // so settles one clk after the rising edge, so sample late
                r_shift <= {r_shift[6:0], spi_so};
                if (r_bit_idx != 3'd0) begin
                    r_bit_idx <= r_bit_idx - 3'd1;
                end
            end

            // Completion beats a simultaneous DATA read clearing rx_valid
            if ((r_state == SPI_DONE) && !w_abort) begin
                r_rx       <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_rx_valid <= 1'b0;
            end

            if (w_data_wr && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_overrun <= 1'b0;
            end

            if (w_rd) begin
                case (bus_addr)
                    REG_DATA:   r_bus_do <= r_rx;
                    REG_CTRL:   r_bus_do <= {5'd0, r_wp_n, r_hold_n, r_cs_n};
                    REG_STATUS: r_bus_do <= {5'd0, r_overrun, r_rx_valid, w_busy};
                    default:    r_bus_do <= w_raw_rd;
                endcase
            end
        end
    end

    assign bus_do     = r_bus_do;
    assign busy       = w_busy;
    assign spi_sck    = w_sck;
    assign spi_si     = w_si;
    assign spi_cs_n   = r_cs_n;
    assign spi_hold_n = r_hold_n;
    assign spi_wp_n   = r_wp_n;

endmodule : pier_eeprom_spi_master
`default_nettype wire
